// File: rtl/axi_simple_master.sv
// Single-outstanding AXI master that turns one CPU request into an AR/R or AW/W/B exchange.
// Define AXI_MASTER_POSTED_WR_EN to report writes done after the AW/W handshakes (B consumed silently).
`timescale 1ns/1ps
module axi_simple_master #(
  parameter logic [3:0] MID    = 4'd0,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_busy,
  output logic                cpu_done,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_err,
  output logic [3:0]          ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [3:0]          RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [3:0]          AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [3:0]          BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     wdata_r, rdata_r;
  logic [DATA_W/8-1:0]   wstrb_r;
  logic                  arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;
  logic                  busy_r, done_r, err_r;
  logic                  accept_s, ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
  logic                  unused_s;

  // SLVERR/DECERR or a response carrying someone else's ID both count as an error.
  function automatic logic resp_err(input logic [1:0] resp, input logic [3:0] id);
    return resp[1] | (id != MID);
  endfunction

  assign accept_s = (state_r == S_IDLE) && cpu_req && !done_r;
  assign ar_hs_s  = arvalid_r && ARREADY;
  assign r_hs_s   = rready_r && RVALID;
  assign aw_hs_s  = awvalid_r && AWREADY;
  assign w_hs_s   = wvalid_r && WREADY;
  assign b_hs_s   = bready_r && BVALID;
  assign unused_s = RLAST;

  // Next-state decode; WREQ leaves once neither AW nor W is still pending.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_s = cpu_we ? S_WREQ : S_RADDR;
        else          state_s = S_IDLE;
      end
      S_RADDR: begin
        if (ar_hs_s) state_s = S_RDATA;
        else         state_s = S_RADDR;
      end
      S_RDATA: begin
        if (r_hs_s) state_s = S_IDLE;
        else        state_s = S_RDATA;
      end
      S_WREQ: begin
        if ((!awvalid_r || aw_hs_s) && (!wvalid_r || w_hs_s)) state_s = S_WRESP;
        else                                                   state_s = S_WREQ;
      end
      S_WRESP: begin
        if (b_hs_s) state_s = S_IDLE;
        else        state_s = S_WRESP;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, registered handshake outputs and the CPU-side result registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r   <= S_IDLE;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      wstrb_r   <= {(DATA_W/8){1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      arvalid_r <= (state_s == S_RADDR);
      rready_r  <= (state_s == S_RDATA);
      bready_r  <= (state_s == S_WRESP);
      busy_r    <= (state_s != S_IDLE);
      done_r    <= 1'b0;
      if (accept_s) begin
        addr_r    <= cpu_addr;
        wdata_r   <= cpu_wdata;
        wstrb_r   <= cpu_wstrb;
        awvalid_r <= cpu_we;
        wvalid_r  <= cpu_we;
      end else begin
        if (aw_hs_s) awvalid_r <= 1'b0;
        if (w_hs_s)  wvalid_r  <= 1'b0;
      end
      if (r_hs_s) begin
        rdata_r <= RDATA;
        err_r   <= resp_err(RRESP, RID);
        done_r  <= 1'b1;
      end
`ifdef AXI_MASTER_POSTED_WR_EN
      if (accept_s) err_r <= 1'b0;
      if ((state_r == S_WREQ) && (state_s == S_WRESP)) begin
        done_r <= 1'b1;
        err_r  <= 1'b0;
      end
      if (b_hs_s) err_r <= err_r | resp_err(BRESP, BID);
`else
      if (b_hs_s) begin
        err_r  <= resp_err(BRESP, BID);
        done_r <= 1'b1;
      end
`endif
    end
  end

  assign cpu_busy  = busy_r;
  assign cpu_done  = done_r;
  assign cpu_rdata = rdata_r;
  assign cpu_err   = err_r;

  assign ARID    = MID;
  assign ARADDR  = addr_r;
  assign ARLEN   = 4'd0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARVALID = arvalid_r;
  assign RREADY  = rready_r;

  assign AWID    = MID;
  assign AWADDR  = addr_r;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_r;
  assign WDATA   = wdata_r;
  assign WSTRB   = wstrb_r;
  assign WLAST   = 1'b1;
  assign WVALID  = wvalid_r;
  assign BREADY  = bready_r;

endmodule

// File: doc/axi_simple_master.md
AXI_SIMPLE_MASTER -- requirements
Module: axi_simple_master

Interface
- REQ-001 SHALL have parameter MID, default 4'd0: AR/AW ID driven on every transaction.
- REQ-002 SHALL have parameter ADDR_W, default 32: address width.
- REQ-003 SHALL have parameter DATA_W, default 32: data width; WSTRB width = DATA_W/8.
- REQ-004 SHALL use one clock; reset is synchronous and active-high.
- REQ-005 ACLK  in  1  clock; all logic on rising edge.
- REQ-006 ARESET  in  1  synchronous active-high reset.
- REQ-007 cpu_req  in  1  request strobe, sampled only in IDLE.
- REQ-008 cpu_we  in  1  1 = write, 0 = read.
- REQ-009 cpu_addr / cpu_wdata / cpu_wstrb  in  ADDR_W / DATA_W / DATA_W/8  request payload.
- REQ-010 cpu_busy  out  1  high whenever state != IDLE.
- REQ-011 cpu_done  out  1  one-cycle completion pulse.
- REQ-012 cpu_rdata / cpu_err  out  DATA_W / 1  read data; error = RESP[1] of the completing response.
- REQ-013 ARID, ARADDR, ARVALID  out  4, ADDR_W, 1;  ARREADY  in  1.
- REQ-014 RID, RDATA, RRESP, RLAST, RVALID  in  4, DATA_W, 2, 1, 1;  RREADY  out  1.
- REQ-015 AWID, AWADDR, AWVALID  out  4, ADDR_W, 1;  AWREADY  in  1.
- REQ-016 WDATA, WSTRB, WLAST, WVALID  out  DATA_W, DATA_W/8, 1, 1;  WREADY  in  1.
- REQ-017 BID, BRESP, BVALID  in  4, 2, 1;  BREADY  out  1.
- REQ-018 ARLEN/AWLEN, ARSIZE/AWSIZE, ARBURST/AWBURST  out  4, 3, 2  constant 0, 3'b010, INCR (2'b01); WLAST constant 1.

Function
- REQ-019 States: IDLE, RADDR, RDATA, WREQ, WRESP; one outstanding transaction.
- REQ-020 IDLE & cpu_req: register addr/wdata/wstrb/we; next state RADDR (we=0) or WREQ (we=1).
- REQ-021 RADDR: ARVALID=1 with registered address; held stable until ARREADY; on handshake -> RDATA.
- REQ-022 RDATA: RREADY=1; on RVALID capture RDATA into cpu_rdata, RRESP[1] into cpu_err, pulse cpu_done next cycle, -> IDLE.
- REQ-023 WREQ: AWVALID and WVALID both asserted on entry; each deasserts independently after own handshake (same-cycle or either order); -> WRESP once both done.
- REQ-024 WRESP: BREADY=1; on BVALID latch BRESP[1] into cpu_err, pulse cpu_done, -> IDLE.
- REQ-025 cpu_done and new cpu_req accept SHALL NOT occur same cycle; minimum 1 IDLE cycle between transactions.
- REQ-026 VALID SHALL never deassert before handshake; payload SHALL not change while VALID high.
- REQ-027 RID/BID not equal to MID SHALL still complete the transaction and set cpu_err=1.
- REQ-028 cpu_rdata and cpu_err SHALL hold value until next completion.
- REQ-029 Minimum read latency: req accept -> cpu_done = 3 cycles with ARREADY and RVALID tied high.

Reset
- REQ-030 ARESET high SHALL force state IDLE; all VALID/READY outputs, cpu_done, cpu_busy, cpu_err = 0; cpu_rdata = 0.
- REQ-031 Reset mid-transaction SHALL abandon it immediately with no cpu_done pulse.

Configuration
- REQ-032 Macro AXI_MASTER_POSTED_WR_EN: defined -> cpu_done pulses (cpu_err=0) the cycle after both AW and W handshakes; B response then consumed silently, cpu_busy stays high until BVALID; a BRESP error sets sticky cpu_err, cleared on next accept.
- REQ-033 Undefined -> cpu_done for writes only after B handshake (REQ-024).

Verification
- REQ-034 Read 0x0000_1000, ARREADY/RVALID high, RDATA 0xDEAD_BEEF, RRESP OKAY -> cpu_done 3 cycles after accept, cpu_rdata 0xDEAD_BEEF, cpu_err 0.
- REQ-035 Write 0x10 data 0x1234_5678 strb 4'b0011, AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles, single BREADY handshake, cpu_done.
- REQ-036 Read to unmapped address, responder returns DECERR (2'b11) -> cpu_done with cpu_err 1.
- REQ-037 BID = 4'h5 with MID = 0 -> cpu_err 1, state returns IDLE.
- REQ-038 ARESET asserted while in RDATA -> next cycle all outputs 0, no cpu_done; subsequent read completes normally.
- REQ-039 AXI_MASTER_POSTED_WR_EN defined, BVALID delayed 5 cycles -> cpu_done 1 cycle after AW/W handshakes, cpu_busy high until BVALID.
